// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter and its grant picker.
package mem_arb_pkg;
  localparam int NREQ   = 2;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {ARB, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant picker; a held lock restricts the grant to its owner.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic            rr_ptr,
  input  arb_state_t      state,
  input  logic            owner,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (state == LOCKED) begin
      gnt[owner] = valid[owner];
    end else if (valid == 2'b11) begin
      gnt[rr_ptr] = 1'b1;
    end else begin
      gnt = valid;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the CPU port (p0) and debug/DMA port (p1) onto a single-port 256x8
// data memory, with registered one-cycle responses and bounded lock sequences.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              lock_timeout
);

  localparam logic [3:0] CNT_LAST = 4'(LOCK_MAX - 1);

  arb_state_t        state;
  logic              owner;
  logic              rr_ptr;
  logic [3:0]        lock_cnt;

  logic [NREQ-1:0]   valid;
  logic [NREQ-1:0]   gnt_raw;
  logic [NREQ-1:0]   gnt_p0;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;

  logic [NREQ-1:0]   rsp_vld_p1;
  logic [DATA_W-1:0] rsp_rdata0_p1;
  logic [DATA_W-1:0] rsp_rdata1_p1;
  logic              timeout_p1;

  assign valid = {p1_valid, p0_valid};

  rr_arb2 u_pick (
    .valid  (valid),
    .rr_ptr (rr_ptr),
    .state  (state),
    .owner  (owner),
    .gnt    (gnt_raw)
  );

  // Stage 0: grant and memory drive; reset blocks every grant and therefore every write.
  assign gnt_p0   = rst ? '0 : gnt_raw;
  assign p0_ready = gnt_p0[0];
  assign p1_ready = gnt_p0[1];

  always_comb begin
    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_wd   = '0;
    if (gnt_p0[0]) begin
      sel_we   = p0_we;
      sel_lock = p0_lock;
      sel_addr = p0_addr;
      sel_wd   = p0_wdata;
    end else if (gnt_p0[1]) begin
      sel_we   = p1_we;
      sel_lock = p1_lock;
      sel_addr = p1_addr;
      sel_wd   = p1_wdata;
    end
  end

  assign mem_we   = sel_we;
  assign mem_addr = sel_addr;
  assign mem_wd   = sel_wd;

  // Stage 1: registered responses plus arbitration/lock state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB;
      owner         <= 1'b0;
      rr_ptr        <= 1'b0;
      lock_cnt      <= '0;
      rsp_vld_p1    <= '0;
      rsp_rdata0_p1 <= '0;
      rsp_rdata1_p1 <= '0;
      timeout_p1    <= 1'b0;
    end else begin
      timeout_p1 <= 1'b0;
      rsp_vld_p1 <= gnt_p0;
      if (gnt_p0[0]) rsp_rdata0_p1 <= sel_we ? '0 : mem_rd;
      if (gnt_p0[1]) rsp_rdata1_p1 <= sel_we ? '0 : mem_rd;
      case (state)
        ARB: begin
          if (|gnt_p0) begin
            rr_ptr <= gnt_p0[0];
            if (sel_lock) begin
              state    <= LOCKED;
              owner    <= gnt_p0[1];
              lock_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          // Occupancy counts every cycle, so an idle owner still times out.
          if (gnt_p0[owner] && !sel_lock) begin
            state <= ARB;
          end else if (lock_cnt == CNT_LAST) begin
            state      <= ARB;
            timeout_p1 <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 4'd1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign p0_rsp_valid = rsp_vld_p1[0];
  assign p1_rsp_valid = rsp_vld_p1[1];
  assign p0_rsp_rdata = rsp_rdata0_p1;
  assign p1_rsp_rdata = rsp_rdata1_p1;
  assign lock_timeout = timeout_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Table-driven bench for data_mem_arbiter with a response scoreboard and a memory model.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_valid, p0_ready, p0_we, p0_lock, p0_rsp_valid;
  logic [7:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic       p1_valid, p1_ready, p1_we, p1_lock, p1_rsp_valid;
  logic [7:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic       mem_we, lock_timeout;
  logic [7:0] mem_addr, mem_wd, mem_rd;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;
  assign mem_rd = mem[mem_addr];

  data_mem_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_lock(p0_lock), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .lock_timeout(lock_timeout)
  );

  typedef struct {
    logic       rst;
    logic [1:0] v, we, lk;
    logic [7:0] a0, d0, a1, d1;
    logic [1:0] rdy;
    logic       to;
  } vec_t;

  typedef struct {
    int         due;
    logic       port;
    logic [7:0] rdata;
  } rsp_t;

  rsp_t sbq[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[24];

  function automatic vec_t mk(input logic r, input logic [1:0] v, we, lk,
                              input logic [7:0] a0, d0, a1, d1,
                              input logic [1:0] rdy, input logic to);
    vec_t t;
    t.rst = r; t.v = v; t.we = we; t.lk = lk;
    t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
    t.rdy = rdy; t.to = to;
    return t;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    logic       e_we;
    logic [7:0] e_addr, e_wd;
    logic [1:0] e_rv;
    rsp_t       r;
    rst      = t.rst;
    p0_valid = t.v[0];  p0_we = t.we[0]; p0_lock = t.lk[0]; p0_addr = t.a0; p0_wdata = t.d0;
    p1_valid = t.v[1];  p1_we = t.we[1]; p1_lock = t.lk[1]; p1_addr = t.a1; p1_wdata = t.d1;
    @(negedge clk);
    e_we = 1'b0; e_addr = 8'h00; e_wd = 8'h00;
    if (t.rdy[0]) begin
      e_we = t.we[0]; e_addr = t.a0; e_wd = t.d0;
    end else if (t.rdy[1]) begin
      e_we = t.we[1]; e_addr = t.a1; e_wd = t.d1;
    end
    chk("p0_ready", {7'd0, p0_ready}, {7'd0, t.rdy[0]});
    chk("p1_ready", {7'd0, p1_ready}, {7'd0, t.rdy[1]});
    chk("mem_we", {7'd0, mem_we}, {7'd0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wd", mem_wd, e_wd);
    chk("lock_timeout", {7'd0, lock_timeout}, {7'd0, t.to});
    e_rv = 2'b00;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      r = sbq.pop_front();
      e_rv[r.port] = 1'b1;
      if (r.port) chk("p1_rsp_rdata", p1_rsp_rdata, r.rdata);
      else        chk("p0_rsp_rdata", p0_rsp_rdata, r.rdata);
    end
    chk("p0_rsp_valid", {7'd0, p0_rsp_valid}, {7'd0, e_rv[0]});
    chk("p1_rsp_valid", {7'd0, p1_rsp_valid}, {7'd0, e_rv[1]});
    if (t.rst) begin
      sbq.delete();
    end else if (t.rdy[0]) begin
      r.due = cyc + 1; r.port = 1'b0; r.rdata = t.we[0] ? 8'h00 : ref_mem[t.a0];
      sbq.push_back(r);
      if (t.we[0]) ref_mem[t.a0] = t.d0;
    end else if (t.rdy[1]) begin
      r.due = cyc + 1; r.port = 1'b1; r.rdata = t.we[1] ? 8'h00 : ref_mem[t.a1];
      sbq.push_back(r);
      if (t.we[1]) ref_mem[t.a1] = t.d1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end

    // contention from reset: p0, p1, p0, p1
    tbl[0]  = mk(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h11, 8'h02, 8'h22, 2'b01, 0);
    tbl[1]  = mk(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h11, 8'h02, 8'h22, 2'b10, 0);
    tbl[2]  = mk(0, 2'b11, 2'b00, 2'b00, 8'h03, 8'h11, 8'h04, 8'h22, 2'b01, 0);
    tbl[3]  = mk(0, 2'b11, 2'b00, 2'b00, 8'h03, 8'h11, 8'h04, 8'h22, 2'b10, 0);
    // single write then read-back
    tbl[4]  = mk(0, 2'b01, 2'b01, 2'b00, 8'h10, 8'hA5, 8'h00, 8'h00, 2'b01, 0);
    tbl[5]  = mk(0, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 0);
    // cross-port ordering
    tbl[6]  = mk(0, 2'b11, 2'b10, 2'b00, 8'h20, 8'h00, 8'h20, 8'h3C, 2'b10, 0);
    tbl[7]  = mk(0, 2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 2'b01, 0);
    // lock RMW by p1
    tbl[8]  = mk(0, 2'b11, 2'b00, 2'b10, 8'h30, 8'h00, 8'h40, 8'h00, 2'b10, 0);
    tbl[9]  = mk(0, 2'b11, 2'b10, 2'b00, 8'h30, 8'h00, 8'h40, 8'h77, 2'b10, 0);
    tbl[10] = mk(0, 2'b01, 2'b00, 2'b00, 8'h30, 8'h00, 8'h00, 8'h00, 2'b01, 0);
    // lock held by p1 indefinitely: 4 locked cycles then timeout
    tbl[11] = mk(0, 2'b11, 2'b00, 2'b10, 8'h31, 8'h00, 8'h41, 8'h00, 2'b10, 0);
    tbl[12] = mk(0, 2'b11, 2'b00, 2'b10, 8'h31, 8'h00, 8'h41, 8'h00, 2'b10, 0);
    tbl[13] = mk(0, 2'b11, 2'b00, 2'b10, 8'h31, 8'h00, 8'h41, 8'h00, 2'b10, 0);
    tbl[14] = mk(0, 2'b11, 2'b00, 2'b10, 8'h31, 8'h00, 8'h41, 8'h00, 2'b10, 0);
    tbl[15] = mk(0, 2'b11, 2'b00, 2'b10, 8'h31, 8'h00, 8'h41, 8'h00, 2'b10, 0);
    tbl[16] = mk(0, 2'b11, 2'b00, 2'b10, 8'h31, 8'h00, 8'h41, 8'h00, 2'b01, 1);
    // idle owner still times out
    tbl[17] = mk(0, 2'b11, 2'b00, 2'b10, 8'h32, 8'h00, 8'h42, 8'h00, 2'b10, 0);
    tbl[18] = mk(0, 2'b01, 2'b00, 2'b00, 8'h32, 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tbl[19] = mk(0, 2'b01, 2'b00, 2'b00, 8'h32, 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tbl[20] = mk(0, 2'b01, 2'b00, 2'b00, 8'h32, 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tbl[21] = mk(0, 2'b01, 2'b00, 2'b00, 8'h32, 8'h00, 8'h00, 8'h00, 2'b00, 0);
    tbl[22] = mk(0, 2'b01, 2'b00, 2'b00, 8'h32, 8'h00, 8'h00, 8'h00, 2'b01, 1);
    tbl[23] = mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0);

    // reset held 3 cycles with both ports requesting (p0 attempts a write)
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 2'b11, 2'b01, 2'b11, 8'h10, 8'hFF, 8'h11, 8'hEE, 2'b00, 0));
      chk("rst_p0_rdata", p0_rsp_rdata, 8'h00);
      chk("rst_p1_rdata", p1_rsp_rdata, 8'h00);
    end
    chk("rst_no_write", mem[8'h10], 8'h10 ^ 8'h5A);

    for (int i = 0; i < 24; i++) step(tbl[i]);
    chk("rmw_write", mem[8'h40], 8'h77);

    // reset while p0 holds a lock: lock and pending response are dropped
    step(mk(0, 2'b01, 2'b00, 2'b01, 8'h60, 8'h00, 8'h00, 8'h00, 2'b01, 0));
    step(mk(1, 2'b01, 2'b00, 2'b01, 8'h60, 8'h00, 8'h00, 8'h00, 2'b00, 0));
    step(mk(0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 8'h61, 8'h00, 2'b10, 0));
    // reset returns rr_ptr to p0
    step(mk(0, 2'b01, 2'b00, 2'b00, 8'h62, 8'h00, 8'h00, 8'h00, 2'b01, 0));
    step(mk(1, 2'b11, 2'b00, 2'b00, 8'h62, 8'h00, 8'h63, 8'h00, 2'b00, 0));
    step(mk(0, 2'b11, 2'b00, 2'b00, 8'h63, 8'h00, 8'h64, 8'h00, 2'b01, 0));
    step(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
